// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one pipelined fp32 adder between NumReq requesters.
// Define FP_ADD_SCHED_SUB_EN to honour req_sub_i (sign flip of operand Y).
module fp_add_sched #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned AddLatency = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0][31:0] req_op1_i,
    input  logic [NumReq-1:0][31:0] req_op2_i,
    input  logic [NumReq-1:0]       req_sub_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    output logic [31:0]             rsp_result_o,
    output logic                    busy_o,
    output logic [31:0]             add_x_o,
    output logic [31:0]             add_y_o,
    input  logic [31:0]             add_r_i
);

    localparam int unsigned TagW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [TagW-1:0]   rr_q;
    logic [NumReq-1:0] outstanding_q;
    logic [NumReq-1:0] eligible;
    logic [NumReq-1:0] grant;
    logic [TagW-1:0]   grant_idx;
    logic              grant_vld;
    logic [31:0]       op_y;

    logic [AddLatency:0] pipe_vld_q;
    logic [TagW-1:0]     pipe_tag_q [AddLatency+1];

    always_comb begin
        int unsigned idx;
        idx       = 0;
        eligible  = req_valid_i & ~outstanding_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = TagW'(idx);
            end
        end
        grant = grant_vld ? (NumReq'(1) << grant_idx) : '0;
    end

    assign req_ready_o = grant;

`ifdef FP_ADD_SCHED_SUB_EN
    assign op_y = req_sub_i[grant_idx] ? (req_op2_i[grant_idx] ^ 32'h8000_0000)
                                       : req_op2_i[grant_idx];
`else
    logic unused_sub;
    assign unused_sub = ^req_sub_i;
    assign op_y       = req_op2_i[grant_idx];
`endif

    // The last tag stage lines up with add_r_i, so the result passes straight through.
    assign rsp_valid_o  = pipe_vld_q[AddLatency] ? (NumReq'(1) << pipe_tag_q[AddLatency]) : '0;
    assign rsp_result_o = pipe_vld_q[AddLatency] ? add_r_i : '0;
    assign busy_o       = |outstanding_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= '0;
            outstanding_q <= '0;
            add_x_o       <= '0;
            add_y_o       <= '0;
            pipe_vld_q    <= '0;
            for (int unsigned s = 0; s <= AddLatency; s++) begin
                pipe_tag_q[s] <= '0;
            end
        end else begin
            if (grant_vld) begin
                add_x_o <= req_op1_i[grant_idx];
                add_y_o <= op_y;
                rr_q    <= (grant_idx == TagW'(NumReq - 1)) ? '0 : grant_idx + TagW'(1);
            end
            pipe_vld_q[0] <= grant_vld;
            pipe_tag_q[0] <= grant_idx;
            for (int unsigned s = 1; s <= AddLatency; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_tag_q[s] <= pipe_tag_q[s-1];
            end
            // Set and clear never hit the same bit: a grant requires the bit to be clear.
            outstanding_q <= (outstanding_q | grant) & ~rsp_valid_o;
        end
    end

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed self-checking bench for fp_add_sched (NumReq=4, AddLatency=2)
// with a two-stage behavioural fp32 adder attached to add_x/add_y/add_r.
module tb_fp_add_sched;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       valid = '0;
    logic [3:0]       ready;
    logic [3:0]       sub = '0;
    logic [3:0]       rsp;
    logic [3:0][31:0] op1 = '0;
    logic [3:0][31:0] op2 = '0;
    logic [31:0]      res, ax, ay, ar;
    logic             busy;
    logic [31:0]      r1, r2;
    int               total = 0;
    int               bad = 0;

    fp_add_sched #(.NumReq(4), .AddLatency(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready),
        .req_op1_i(op1), .req_op2_i(op2), .req_sub_i(sub), .rsp_valid_o(rsp),
        .rsp_result_o(res), .busy_o(busy), .add_x_o(ax), .add_y_o(ay), .add_r_i(ar)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // External adder: result appears two cycles after the operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1 <= '0;
            r2 <= '0;
        end else begin
            r1 <= r2f(f2r(ax) + f2r(ay));
            r2 <= r1;
        end
    end
    assign ar = r2;

    task automatic test_reset;
        @(negedge clk); #1;
        total++; if (ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready); end
        total++; if (rsp !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b exp=0000", rsp); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", res); end
        total++; if (ax !== 32'd0 || ay !== 32'd0) begin bad++; $display("FAIL reset_operands got=%h/%h exp=0/0", ax, ay); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_add;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid  = (k == 0) ? 4'b0001 : 4'b0000;
            op1[0] = 32'h3F80_0000;
            op2[0] = 32'h4000_0000;
            #1;
            total++; if (ready !== ((k == 0) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_ready k=%0d got=%b", k, ready); end
            total++; if (busy !== (k >= 1 && k <= 3)) begin bad++; $display("FAIL single_busy k=%0d got=%b", k, busy); end
            total++; if (rsp !== ((k == 3) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_rsp k=%0d got=%b", k, rsp); end
            total++; if (res !== ((k == 3) ? 32'h4040_0000 : 32'd0)) begin bad++; $display("FAIL single_result k=%0d got=%h", k, res); end
            if (k == 1) begin
                total++; if (ax !== 32'h3F80_0000 || ay !== 32'h4000_0000) begin bad++; $display("FAIL single_operands got=%h/%h exp=3f800000/40000000", ax, ay); end
            end
        end
    endtask

    task automatic test_sub;
        logic [31:0] exp_y, exp_r;
`ifdef FP_ADD_SCHED_SUB_EN
        exp_y = 32'hBF80_0000;
        exp_r = 32'h4000_0000;
`else
        exp_y = 32'h3F80_0000;
        exp_r = 32'h4080_0000;
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid  = (k == 0) ? 4'b0010 : 4'b0000;
            op1[1] = 32'h4040_0000;
            op2[1] = 32'h3F80_0000;
            sub    = 4'b0010;
            #1;
            if (k == 0) begin
                total++; if (ready !== 4'b0010) begin bad++; $display("FAIL sub_ready got=%b exp=0010", ready); end
            end
            if (k == 1) begin
                total++; if (ay !== exp_y) begin bad++; $display("FAIL sub_operand_y got=%h exp=%h", ay, exp_y); end
            end
            total++; if (rsp !== ((k == 3) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL sub_rsp k=%0d got=%b", k, rsp); end
            if (k == 3) begin
                total++; if (res !== exp_r) begin bad++; $display("FAIL sub_result got=%h exp=%h", res, exp_r); end
            end
        end
        sub = '0;
    endtask

    task automatic test_contention;
        logic [3:0]  pend;
        logic [31:0] rtab [4];
        rtab[0] = 32'h4000_0000; rtab[1] = 32'h4040_0000;
        rtab[2] = 32'h4080_0000; rtab[3] = 32'h40A0_0000;
        // rr is 2 here; a lone request on 3 moves it to 0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid  = (k == 0) ? 4'b1000 : 4'b0000;
            op1[3] = 32'h3F80_0000;
            op2[3] = 32'h3F80_0000;
            #1;
            if (k == 0) begin
                total++; if (ready !== 4'b1000) begin bad++; $display("FAIL prep3_ready got=%b exp=1000", ready); end
            end
            if (k == 3) begin
                total++; if (rsp !== 4'b1000 || res !== 32'h4000_0000) begin bad++; $display("FAIL prep3_rsp got=%b/%h exp=1000/40000000", rsp, res); end
            end
        end
        op1 = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        op2 = {4{32'h3F80_0000}};
        pend = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            valid = pend;
            #1;
            total++; if (ready !== ((k < 4) ? (4'b0001 << k) : 4'b0000)) begin bad++; $display("FAIL cont_ready k=%0d got=%b", k, ready); end
            total++; if (rsp !== ((k >= 3 && k <= 6) ? (4'b0001 << (k - 3)) : 4'b0000)) begin bad++; $display("FAIL cont_rsp k=%0d got=%b", k, rsp); end
            if (k >= 3 && k <= 6) begin
                total++; if (res !== rtab[k-3]) begin bad++; $display("FAIL cont_result k=%0d got=%h exp=%h", k, res, rtab[k-3]); end
            end
            pend = pend & ~ready;
        end
        // all valid again: rr must be back at 0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid = (k == 0) ? 4'b1111 : 4'b0000;
            #1;
            if (k == 0) begin
                total++; if (ready !== 4'b0001) begin bad++; $display("FAIL cont_rr_wrap got=%b exp=0001", ready); end
            end
            if (k == 3) begin
                total++; if (rsp !== 4'b0001 || res !== 32'h4000_0000) begin bad++; $display("FAIL cont_rr_rsp got=%b/%h exp=0001/40000000", rsp, res); end
            end
        end
    endtask

    task automatic test_fairness;
        logic [3:0] er [9];
        logic [3:0] es [9];
        logic       v1, v3;
        int         g3;
        er = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        es = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        // rr is 1 here; a lone request on 2 moves it to 3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid  = (k == 0) ? 4'b0100 : 4'b0000;
            op1[2] = 32'h4040_0000;
            op2[2] = 32'h3F80_0000;
            #1;
            if (k == 0) begin
                total++; if (ready !== 4'b0100) begin bad++; $display("FAIL prep2_ready got=%b exp=0100", ready); end
            end
            if (k == 3) begin
                total++; if (rsp !== 4'b0100 || res !== 32'h4080_0000) begin bad++; $display("FAIL prep2_rsp got=%b/%h exp=0100/40800000", rsp, res); end
            end
        end
        op1[1] = 32'h3F80_0000; op2[1] = 32'h3F80_0000;
        op1[3] = 32'h4000_0000; op2[3] = 32'h4000_0000;
        v1 = 1'b1; v3 = 1'b1; g3 = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            valid = {v3, 1'b0, v1, 1'b0};
            #1;
            total++; if (ready !== er[k]) begin bad++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, ready, er[k]); end
            total++; if (rsp !== es[k]) begin bad++; $display("FAIL fair_rsp k=%0d got=%b exp=%b", k, rsp, es[k]); end
            if (es[k] != 4'b0000) begin
                total++; if (res !== ((es[k] == 4'b1000) ? 32'h4080_0000 : 32'h4000_0000)) begin bad++; $display("FAIL fair_result k=%0d got=%h", k, res); end
            end
            if (ready[1]) v1 = 1'b0;
            if (ready[3]) begin
                g3++;
                if (g3 == 2) v3 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        op1[2] = 32'h4040_0000;
        op2[2] = 32'h3F80_0000;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            valid = (k <= 8) ? 4'b0100 : 4'b0000;
            #1;
            total++; if (ready !== ((k == 0 || k == 4 || k == 8) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b", k, ready); end
            total++; if (rsp !== ((k == 3 || k == 7 || k == 11) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL b2b_rsp k=%0d got=%b", k, rsp); end
            total++; if (busy !== !(k == 0 || k == 4 || k == 8 || k == 12)) begin bad++; $display("FAIL b2b_busy k=%0d got=%b", k, busy); end
            if (k == 11) begin
                total++; if (res !== 32'h4080_0000) begin bad++; $display("FAIL b2b_result got=%h exp=40800000", res); end
            end
        end
    endtask

    task automatic test_reset_mid;
        op1[0] = 32'h3F80_0000;
        op2[0] = 32'h4000_0000;
        @(negedge clk);
        valid = 4'b0001;
        #1;
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL rmid_issue_ready got=%b exp=0001", ready); end
        @(negedge clk);
        valid = 4'b0000;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (ax !== 32'd0 || ay !== 32'd0) begin bad++; $display("FAIL rmid_operands got=%h/%h exp=0/0", ax, ay); end
        total++; if (busy !== 1'b0 || rsp !== 4'b0000 || ready !== 4'b0000) begin bad++; $display("FAIL rmid_async got busy=%b rsp=%b ready=%b exp=0/0000/0000", busy, rsp, ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            total++; if (rsp !== 4'b0000) begin bad++; $display("FAIL rmid_ghost_rsp k=%0d got=%b exp=0000", k, rsp); end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid = (k == 0) ? 4'b1111 : 4'b0000;
            #1;
            if (k == 0) begin
                total++; if (ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_ready got=%b exp=0001", ready); end
            end
            total++; if (rsp !== ((k == 3) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL rmid_rsp k=%0d got=%b", k, rsp); end
            if (k == 3) begin
                total++; if (res !== 32'h4040_0000) begin bad++; $display("FAIL rmid_result got=%h exp=40400000", res); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
